// File: rtl/mm_pkg.sv
// Shared definitions for the mm coprocessor front_end / back_end / write path.
//   MM_ADDR_W, MM_DATA_W : default buffer address and data widths
//   mm_state_t           : common IDLE/RUN/DONE state encoding
package mm_pkg;

  localparam int unsigned MM_ADDR_W = 12;
  localparam int unsigned MM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mm_state_t;

endpackage

// File: rtl/mm_wr_port_reg.sv
// Output-BRAM write port register: one cycle of latency on we/addr/din.
// Address and data only load on a write, so they hold between writes.
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   i_we/i_addr/i_din  write request from the controller
//   o_we/o_addr/o_din  registered write port to the BRAM
module mm_wr_port_reg #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_din
);

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_we <= i_we;
      if (i_we) begin
        r_addr <= i_addr;
        r_din  <= i_din;
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_din  = r_din;

endmodule

// File: rtl/back_end_wr_ctrl.sv
// Output-side write controller downstream of the back_end FSM.
// Holds the programmed transfer size and the output-buffer address, tells
// back_end when the size is zero and when the final word is reached, and
// drives the registered output-BRAM write port.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | size_r tracks size input; start with nonzero size -> RUN
// RUN   | accepting back_end beats; last flags the final address
// DONE  | transfer complete, last held high until host clear
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   start, size, clear   host control
//   en, wren, din        from back_end / actor
//   zero, last           to back_end
//   mem_we/addr/din      registered output-BRAM write port
//   wr_count             words written in the current/last transfer
//   err                  sticky protocol error
module back_end_wr_ctrl
  import mm_pkg::*;
#(
  parameter  int unsigned ADDR_W = MM_ADDR_W,
  parameter  int unsigned DATA_W = MM_DATA_W,
  localparam int unsigned SIZE_W = ADDR_W + 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  input  logic              clear,
  input  logic              en,
  input  logic              wren,
  input  logic [DATA_W-1:0] din,
  output logic              zero,
  output logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [SIZE_W-1:0] wr_count,
  output logic              err
);

  localparam logic [SIZE_W-1:0] MAX_SIZE = {1'b1, {ADDR_W{1'b0}}};

  mm_state_t         r_state;
  logic [SIZE_W-1:0] r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [SIZE_W-1:0] r_wr_count;
  logic              r_err;

  logic [SIZE_W-1:0] w_size_clamped;
  logic              w_at_final;
  logic              w_wr_fire;

  assign w_size_clamped = (size > MAX_SIZE) ? MAX_SIZE : size;

  // Compare in SIZE_W so a full 2**ADDR_W transfer ends at the top address.
  assign w_at_final = ({1'b0, r_addr} == (r_size - SIZE_W'(1)));
  assign w_wr_fire  = wren && (r_state == RUN);

  assign zero     = (r_size == '0);
  assign last     = ((r_state == RUN) && w_at_final) || (r_state == DONE);
  assign wr_count = r_wr_count;
  assign err      = r_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_size     <= '0;
      r_addr     <= '0;
      r_wr_count <= '0;
      r_err      <= 1'b0;
    end else begin
      if (wren && (r_state != RUN))
        r_err <= 1'b1;
      if (en && !wren)
        r_err <= 1'b1;
      if (en && wren && (r_state == RUN) && w_at_final)
        r_err <= 1'b1;

      case (r_state)
        IDLE: begin
          r_size <= w_size_clamped;
          // A zero-size start still restarts the count; back_end bounces
          // through its own DONE without us leaving IDLE.
          if (start) begin
            r_addr     <= '0;
            r_wr_count <= '0;
            if (r_size != '0)
              r_state <= RUN;
          end
        end
        RUN: begin
          if (wren) begin
            r_wr_count <= r_wr_count + SIZE_W'(1);
            if (en && !w_at_final)
              r_addr <= r_addr + ADDR_W'(1);
            if (w_at_final)
              r_state <= DONE;
          end
        end
        DONE: begin
          if (clear)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mm_wr_port_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_port (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_we    (w_wr_fire),
    .i_addr  (r_addr),
    .i_din   (din),
    .o_we    (mem_we),
    .o_addr  (mem_addr),
    .o_din   (mem_din)
  );

endmodule

// File: tb/tb_back_end_wr_ctrl.sv
module tb_back_end_wr_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int SIZE_W = ADDR_W + 1;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              start;
  logic [SIZE_W-1:0] size;
  logic              clear;
  logic              en;
  logic              wren;
  logic [DATA_W-1:0] din;
  logic              zero;
  logic              last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [SIZE_W-1:0] wr_count;
  logic              err;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  back_end_wr_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .start    (start),
    .size     (size),
    .clear    (clear),
    .en       (en),
    .wren     (wren),
    .din      (din),
    .zero     (zero),
    .last     (last),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .wr_count (wr_count),
    .err      (err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Every BRAM write must match the next expected (addr, data) pair.
  always @(negedge aclk) begin
    if (aresetn && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=none", mem_addr, mem_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_din !== e.data) begin
          errors++;
          $display("FAIL write addr=%0h data=%0h required addr=%0h data=%0h",
                   mem_addr, mem_din, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic e, input logic w, input logic [DATA_W-1:0] d);
    en   = e;
    wren = w;
    din  = d;
    tick();
    en   = 1'b0;
    wren = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #3;
    aresetn = 1'b1;
    tick();
  endtask

  logic [DATA_W-1:0] d4 [3];

  initial begin
    aresetn = 1'b0;
    start = 1'b0; size = '0; clear = 1'b0;
    en = 1'b0; wren = 1'b0; din = '0;
    #12;
    chk("reset_mem_we", mem_we, 0);
    chk("reset_wr_count", wr_count, 0);
    chk("reset_err", err, 0);
    chk("reset_zero", zero, 1);
    chk("reset_last", last, 0);
    aresetn = 1'b1;

    // 1: size 4, back-to-back beats
    size = 13'd4;
    tick();
    chk("t1_zero", zero, 0);
    pulse_start();
    chk("t1_last_entry", last, 0);
    push(0, 32'hA000_0000); push(1, 32'hA000_0001);
    push(2, 32'hA000_0002); push(3, 32'hA000_0003);
    beat(1, 1, 32'hA000_0000);
    beat(1, 1, 32'hA000_0001);
    beat(1, 1, 32'hA000_0002);
    chk("t1_last_beat4", last, 1);
    beat(0, 1, 32'hA000_0003);
    chk("t1_done_last", last, 1);
    chk("t1_wr_count", wr_count, 4);
    chk("t1_err", err, 0);
    pulse_clear();
    chk("t1_last_after_clear", last, 0);

    // 2: zero-size transfer
    size = 13'd0;
    tick();
    chk("t2_zero", zero, 1);
    pulse_start();
    chk("t2_last", last, 0);
    chk("t2_wr_count", wr_count, 0);
    tick();
    chk("t2_last_idle", last, 0);
    chk("t2_err", err, 0);

    // 3: size 1, single beat, DONE held, clear+start collide
    size = 13'd1;
    tick();
    pulse_start();
    chk("t3_last_entry", last, 1);
    push(0, 32'hB111_0001);
    beat(0, 1, 32'hB111_0001);
    chk("t3_done_last", last, 1);
    chk("t3_wr_count", wr_count, 1);
    tick(); tick();
    pulse_start();
    chk("t3_start_ignored", last, 1);
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    chk("t3_last_after_clear", last, 0);
    tick();
    chk("t3_start_lost", last, 0);
    chk("t3_wr_count_hold", wr_count, 1);

    // 4: size 3 with two idle cycles between beats
    d4[0] = 32'hC0DE_0000; d4[1] = 32'hC0DE_0011; d4[2] = 32'hC0DE_0022;
    size = 13'd3;
    tick();
    pulse_start();
    push(0, d4[0]); push(1, d4[1]); push(2, d4[2]);
    for (int i = 0; i < 3; i++) begin
      beat((i < 2) ? 1'b1 : 1'b0, 1'b1, d4[i]);
      din = 32'hDEAD_0000 + i;
      tick(); tick();
      chk("t4_wr_count", wr_count, i + 1);
      chk("t4_mem_din_hold", mem_din, d4[i]);
      chk("t4_mem_addr_hold", mem_addr, i);
      chk("t4_last", last, (i >= 1) ? 1 : 0);
    end
    pulse_clear();

    // 5: protocol errors
    chk("t5_err_before", err, 0);
    beat(0, 1, 32'h0BAD_0BAD);
    chk("t5_stray_mem_we", mem_we, 0);
    chk("t5_stray_err", err, 1);
    do_reset();
    chk("t5_err_reset", err, 0);
    size = 13'd3;
    tick();
    pulse_start();
    push(0, 32'hE000_0000); push(1, 32'hE000_0001); push(2, 32'hE000_0002);
    beat(1, 1, 32'hE000_0000);
    beat(1, 1, 32'hE000_0001);
    chk("t5_err_mid", err, 0);
    beat(1, 1, 32'hE000_0002);
    chk("t5_final_en_err", err, 1);
    chk("t5_final_addr", mem_addr, 2);
    chk("t5_last", last, 1);
    pulse_clear();
    tick();
    chk("t5_err_sticky", err, 1);

    // 6: reset mid-transfer, then a clean transfer
    do_reset();
    size = 13'd8;
    tick();
    pulse_start();
    push(0, 32'hF000_0000); push(1, 32'hF000_0001); push(2, 32'hF000_0002);
    beat(1, 1, 32'hF000_0000);
    beat(1, 1, 32'hF000_0001);
    beat(1, 1, 32'hF000_0002);
    beat(1, 1, 32'hF000_0003);
    aresetn = 1'b0;
    #2;
    chk("t6_mem_we", mem_we, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_din", mem_din, 0);
    chk("t6_wr_count", wr_count, 0);
    chk("t6_err", err, 0);
    chk("t6_last", last, 0);
    chk("t6_zero", zero, 1);
    #2;
    aresetn = 1'b1;
    size = 13'd2;
    tick();
    pulse_start();
    push(0, 32'h5A5A_0000); push(1, 32'h5A5A_0001);
    beat(1, 1, 32'h5A5A_0000);
    chk("t6b_last", last, 1);
    beat(0, 1, 32'h5A5A_0001);
    chk("t6b_done", last, 1);
    chk("t6b_wr_count", wr_count, 2);
    chk("t6b_err", err, 0);
    pulse_clear();
    chk("t6b_last_clear", last, 0);
    tick(); tick();
    chk("pending_writes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
